clz_denorm: RTL and testbench

- Inverse of the leading-zero counter: takes a normalised mantissa plus its leading-zero count and valid flag, and restores the original un-normalised word.
- Uses an iterative logarithmic right shifter: one shift stage (by 2^k) per clock, so area stays small for wide datapaths.
- Sits on the output side of the Newton iteration datapath, where results computed in normalised form are converted back to fixed point.
- Valid/ready handshake on both input and output.

---
 rtl/clz_denorm_if.sv | 28 ++
 rtl/clz_denorm.sv | 114 +++++++++++
 tb/tb_clz_denorm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/clz_denorm_if.sv
// Handshake bundle for the de-normaliser: input side (mantissa, count,
// zero flag) and output side (restored word, normalisation error).
interface clz_denorm_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [CW-1:0]    in_count;
  logic             in_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             norm_err;

  // Producer / consumer side that talks to the de-normaliser
  modport master (
    output in_valid, in_mant, in_count, in_zero, out_ready,
    input  in_ready, out_valid, out_data, norm_err
  );

  // The de-normaliser itself
  modport slave (
    input  in_valid, in_mant, in_count, in_zero, out_ready,
    output in_ready, out_valid, out_data, norm_err
  );
endinterface

// File: rtl/clz_denorm.sv
// Iterative de-normaliser: restores in_mant >> in_count one logarithmic
// stage (shift by 1, 2, 4, ...) per clock, so a result always takes CW
// cycles regardless of the count. A latched zero flag forces the result
// to zero; norm_err flags a mantissa whose MSB was not set.
module clz_denorm #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  clz_denorm_if.slave      bus,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_K = CW'(CW - 1);

  state_t           state_q;
  logic [CW-1:0]    k_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    count_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             norm_err_q;
  logic             busy_q;

  logic [WIDTH-1:0] shifted_d;
  logic             stage_en_d;

  // Pick the fixed-distance shift belonging to the current stage k; each
  // candidate is a constant shift, so this is a mux rather than a barrel.
  always_comb begin
    shifted_d  = data_q;
    stage_en_d = 1'b0;
    for (int s = 0; s < CW; s++) begin
      if (k_q == CW'(s)) begin
        shifted_d  = data_q >> (1 << s);
        stage_en_d = count_q[s];
      end
    end
  end

  // Control FSM and data register; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      data_q      <= '0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      norm_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_mant;
            count_q    <= bus.in_count;
            zero_q     <= bus.in_zero;
            norm_err_q <= ~bus.in_zero & ~bus.in_mant[WIDTH-1];
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (stage_en_d) begin
            data_q <= shifted_d;
          end
          k_q <= k_q + 1'b1;
          if (k_q == LAST_K) begin
            // An all-zero original word overrides whatever the mantissa held.
            if (zero_q) begin
              data_q <= '0;
            end
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            norm_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.norm_err  = norm_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_clz_denorm.sv
// Directed and soak bench for clz_denorm at WIDTH=8 (three shift stages).
module tb_clz_denorm;

  localparam int WIDTH = 8;
  localparam int CW    = 3;
  localparam int SOAK  = 1000;

  logic clk;
  logic rst;
  logic busy;

  int total;
  int bad;

  clz_denorm_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  clz_denorm #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full directed transaction with out_ready held high, checking
  // the exact latency, the result, and the return to IDLE
  task automatic applyStimulus(input string tag, input logic [7:0] mant,
                               input logic [2:0] cnt, input logic zero,
                               input logic [7:0] expData, input logic expErr);
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_mant   = mant;
    bus.in_count  = cnt;
    bus.in_zero   = zero;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_mant  = ~mant;
    bus.in_count = ~cnt;
    bus.in_zero  = ~zero;
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_early0"}, bus.out_valid, 0);
    for (int i = 1; i < CW; i++) begin
      @(negedge clk);
      checkOutput({tag, "_early"}, bus.out_valid, 0);
    end
    @(negedge clk);
    checkOutput({tag, "_valid"}, bus.out_valid, 1);
    checkOutput({tag, "_data"}, bus.out_data, expData);
    checkOutput({tag, "_err"}, bus.norm_err, expErr);
    @(negedge clk);
    checkOutput({tag, "_released"}, {bus.out_valid, bus.in_ready, busy}, 3'b010);
  endtask

  logic [7:0] expQ[$];
  int         received;

  initial begin
    total         = 0;
    bad           = 0;
    received      = 0;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_count  = '0;
    bus.in_zero   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    #1;
    checkOutput("reset_state", {bus.in_ready, bus.out_valid, bus.norm_err, busy, bus.out_data},
                {4'b1000, 8'h00});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    applyStimulus("basic",     8'b1011_0000, 3'd3, 1'b0, 8'b0001_0110, 1'b0);
    applyStimulus("count0",    8'hA5,        3'd0, 1'b0, 8'hA5,        1'b0);
    applyStimulus("count7",    8'h80,        3'd7, 1'b0, 8'h01,        1'b0);
    applyStimulus("zeroflag",  8'hFF,        3'd5, 1'b1, 8'h00,        1'b0);
    applyStimulus("normerr",   8'h40,        3'd1, 1'b0, 8'h20,        1'b1);
    applyStimulus("count4",    8'hFF,        3'd4, 1'b0, 8'h0F,        1'b0);
    applyStimulus("count6",    8'hC3,        3'd6, 1'b0, 8'h03,        1'b0);

    // Backpressure: result held while out_ready is low and a new input waits
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mant   = 8'hC0;
    bus.in_count  = 3'd2;
    bus.in_zero   = 1'b0;
    @(negedge clk);
    bus.in_mant  = 8'h90;
    bus.in_count = 3'd1;
    for (int i = 0; i < CW; i++) @(negedge clk);
    checkOutput("bp_valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold", {bus.out_valid, bus.in_ready, bus.out_data}, {2'b10, 8'h30});
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("bp_next_accept", {bus.in_ready, busy}, 2'b01);
    for (int i = 0; i < CW; i++) @(negedge clk);
    checkOutput("bp_next_data", {bus.out_valid, bus.out_data}, {1'b1, 8'h48});
    @(negedge clk);

    // Reset in the second SHIFT cycle drops the transaction immediately
    bus.in_valid = 1'b1;
    bus.in_mant  = 8'hF0;
    bus.in_count = 3'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset", {bus.in_ready, bus.out_valid, bus.norm_err, busy, bus.out_data},
                {4'b1000, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < CW + 2; i++) begin
      @(negedge clk);
      checkOutput("midreset_nodrop", bus.out_valid, 0);
    end
    applyStimulus("postreset", 8'h88, 3'd3, 1'b0, 8'h11, 1'b0);

    // Random soak with random backpressure and an in-order scoreboard
    fork
      begin : driver
        logic [7:0] m;
        logic [2:0] c;
        int         guard;
        for (int n = 0; n < SOAK; n++) begin
          @(negedge clk);
          m = 8'($urandom_range(0, 127)) | 8'h80;
          c = 3'($urandom_range(0, 7));
          bus.in_valid = 1'b1;
          bus.in_mant  = m;
          bus.in_count = c;
          bus.in_zero  = 1'b0;
          guard = 0;
          while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 200) checkOutput("soak_accept_timeout", 0, 1);
          expQ.push_back(m >> c);
          @(negedge clk);
          bus.in_valid = 1'b0;
        end
      end
      begin : monitor
        int cycles;
        logic [7:0] want;
        cycles = 0;
        while (received < SOAK && cycles < 40000) begin
          @(negedge clk);
          cycles++;
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
              checkOutput("soak_unexpected", 1, 0);
            end else begin
              want = expQ.pop_front();
              checkOutput("soak_data", {bus.norm_err, bus.out_data}, {1'b0, want});
            end
            received++;
          end
        end
        if (received < SOAK) checkOutput("soak_timeout", received, SOAK);
      end
    join
    @(negedge clk);
    checkOutput("soak_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
